// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, DM requester and memory-port signals of mem_port_arbiter.
// slave = arbiter side, master = environment side (requesters and memory).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  // load/store requester
  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_rd_wr;
  logic [1:0]        dm_size;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              err;
  // shared memory port
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_rd_wr;
  logic [1:0]        mem_access_size;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_rd_wr, dm_size,
           mem_data_out, mem_busy,
    output if_ack, if_rdata, dm_ack, dm_rdata, err,
           mem_en, mem_addr, mem_data_in, mem_rd_wr, mem_access_size
  );

  modport master (
    output if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_rd_wr, dm_size,
           mem_data_out, mem_busy,
    input  if_ack, if_rdata, dm_ack, dm_rdata, err,
           mem_en, mem_addr, mem_data_in, mem_rd_wr, mem_access_size
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (DM).
// Data has priority, bounded by a streak limit while IF waits; each access runs
// IDLE -> ISSUE -> WAIT and is force-completed with err after TIMEOUT busy cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DATA_STREAK = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned SW = (DATA_STREAK < 1) ? 1 : $clog2(DATA_STREAK + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic       {OWN_IF, OWN_DM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_rd_wr_q, mem_rd_wr_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic if_pend, dm_pend, pick_dm;

  // A requester acked this cycle still shows req high; mask it so it is not re-granted.
  always_comb begin
    if_pend = bus.if_req & ~if_ack_q;
    dm_pend = bus.dm_req & ~dm_ack_q;
    pick_dm = dm_pend & (~if_pend | (streak_q != STREAK_MAX));
  end

  // Next-state and output logic for the access sequencer and arbiter.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    streak_d      = streak_q;
    wait_cnt_d    = wait_cnt_q;
    if_ack_d      = 1'b0;
    dm_ack_d      = 1'b0;
    err_d         = 1'b0;
    mem_en_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_size_d    = mem_size_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (if_pend || dm_pend) begin
          // mem_en is registered on grant so it is high exactly for the ISSUE cycle
          mem_en_d = 1'b1;
          state_d  = ST_ISSUE;
          if (pick_dm) begin
            owner_d       = OWN_DM;
            mem_addr_d    = bus.dm_addr;
            mem_data_in_d = bus.dm_wdata;
            mem_rd_wr_d   = bus.dm_rd_wr;
            mem_size_d    = bus.dm_size;
            if (!if_pend)                     streak_d = '0;
            else if (streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
          end else begin
            owner_d       = OWN_IF;
            mem_addr_d    = bus.if_addr;
            mem_data_in_d = '0;
            mem_rd_wr_d   = 1'b1;
            mem_size_d    = 2'b11;
            streak_d      = '0;
          end
        end
      end

      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (!bus.mem_busy) begin
          if (mem_rd_wr_q) begin
            if (owner_q == OWN_DM) dm_rdata_d = bus.mem_data_out;
            else                   if_rdata_d = bus.mem_data_out;
          end
          if (owner_q == OWN_DM) dm_ack_d = 1'b1;
          else                   if_ack_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            if (owner_q == OWN_DM) dm_ack_d = 1'b1;
            else                   if_ack_d = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_IF;
      streak_q      <= '0;
      wait_cnt_q    <= '0;
      if_ack_q      <= 1'b0;
      dm_ack_q      <= 1'b0;
      err_q         <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_rd_wr_q   <= 1'b1;
      mem_size_q    <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      streak_q      <= streak_d;
      wait_cnt_q    <= wait_cnt_d;
      if_ack_q      <= if_ack_d;
      dm_ack_q      <= dm_ack_d;
      err_q         <= err_d;
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_size_q    <= mem_size_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
    end
  end

  assign bus.if_ack          = if_ack_q;
  assign bus.dm_ack          = dm_ack_q;
  assign bus.err             = err_q;
  assign bus.if_rdata        = if_rdata_q;
  assign bus.dm_rdata        = dm_rdata_q;
  assign bus.mem_en          = mem_en_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_data_in     = mem_data_in_q;
  assign bus.mem_rd_wr       = mem_rd_wr_q;
  assign bus.mem_access_size = mem_size_q;

endmodule
